// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Brief    : Immediate extender feeding a 2-entry (head + skid) output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [IN_W-1:0]  immediate,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] output_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    localparam int         C_EXT_W    = OUT_W - IN_W;
    localparam logic [1:0] C_ST_EMPTY = 2'd0;
    localparam logic [1:0] C_ST_ONE   = 2'd1;
    localparam logic [1:0] C_ST_TWO   = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [OUT_W-1:0] r_head;
    logic [OUT_W-1:0] r_skid;
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;
    logic             w_push;
    logic             w_pop;
    logic             w_load_head_in;
    logic             w_load_head_skid;
    logic             w_load_skid;

    // Extension happens before storage so both registers hold final results.
    assign w_sext = {{C_EXT_W{immediate[IN_W-1]}}, immediate};

    always_comb begin
        w_ext = '0;
        case (mode)
            2'b00:   w_ext = {{C_EXT_W{1'b0}}, immediate};
            2'b01:   w_ext = w_sext;
            2'b10:   w_ext = {immediate, {C_EXT_W{1'b0}}};
            default: w_ext = {w_sext[OUT_W-3:0], 2'b00};
        endcase
    end

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state <= C_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        in_ready         = 1'b1;
        out_valid        = 1'b0;
        occupancy        = 2'd0;
        case (r_state)
            C_ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt    = C_ST_ONE;
                    w_load_head_in = 1'b1;
                end
            end
            C_ST_ONE: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
                if (w_push && w_pop) begin
                    w_load_head_in = 1'b1;
                end else if (w_push) begin
                    w_state_nxt = C_ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = C_ST_EMPTY;
                end
            end
            C_ST_TWO: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                occupancy = 2'd2;
                if (w_pop) begin
                    w_state_nxt      = C_ST_ONE;
                    w_load_head_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = C_ST_EMPTY;
            end
        endcase
    end

    // Flush clears the data like reset so a drained buffer reads back as zero.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head_in) begin
                r_head <= w_ext;
            end else if (w_load_head_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_ext;
            end
        end
    end

    assign output_imm = r_head;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Brief    : Directed bench with queue-based reference model for imm_extend_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [15:0] immediate;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] output_imm;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  occupancy;

    logic        flush8;
    logic [7:0]  immediate8;
    logic [1:0]  mode8;
    logic        in_valid8;
    logic        in_ready8;
    logic [15:0] output_imm8;
    logic        out_valid8;
    logic        out_ready8;
    logic [1:0]  occupancy8;

    int checks = 0;
    int errors = 0;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .immediate(immediate),
        .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .output_imm(output_imm), .out_valid(out_valid),
        .out_ready(out_ready), .occupancy(occupancy)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16)) u_dut8 (
        .clk(clk), .reset(reset), .flush(flush8), .immediate(immediate8),
        .mode(mode8), .in_valid(in_valid8), .in_ready(in_ready8),
        .output_imm(output_imm8), .out_valid(out_valid8),
        .out_ready(out_ready8), .occupancy(occupancy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Extension computed arithmetically from the mode definitions.
    function automatic longint unsigned ext_model(input int in_w, input int out_w,
                                                  input longint unsigned imm,
                                                  input logic [1:0] m);
        longint          s;
        longint unsigned r;
        longint unsigned mask;
        mask = (64'd1 << out_w) - 64'd1;
        s = (imm >= (64'd1 << (in_w - 1))) ? longint'(imm) - (longint'(1) << in_w)
                                           : longint'(imm);
        case (m)
            2'b00:   r = imm;
            2'b01:   r = longint'(s);
            2'b10:   r = imm << (out_w - in_w);
            default: r = longint'(s * 4);
        endcase
        return r & mask;
    endfunction

    longint unsigned q[$];
    bit              model_ok  = 1'b0;
    bit              zero_head = 1'b0;
    bit              m_push;
    bit              m_pop;

    always @(posedge clk) begin
        if (reset || flush) begin
            q.delete();
            model_ok  = 1'b1;
            zero_head = 1'b1;
        end else if (model_ok) begin
            m_push = in_valid && (q.size() < 2);
            m_pop  = (q.size() > 0) && out_ready;
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back(ext_model(16, 32, 64'(immediate), mode));
                zero_head = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("occupancy", 64'(occupancy), 64'(q.size()));
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("in_ready", 64'(in_ready), 64'(q.size() < 2));
            if (q.size() > 0)
                check("head", 64'(output_imm), q[0]);
            else if (zero_head)
                check("head_zero", 64'(output_imm), 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] imm, input logic [1:0] m);
        immediate = imm;
        mode      = m;
        in_valid  = 1'b1;
    endtask

    logic [15:0] vec_imm [4] = '{16'h0007, 16'hAAAA, 16'h0F00, 16'h8001};
    logic [1:0]  vec_mode[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] vec_exp [4] = '{32'h00000007, 32'hFFFFAAAA, 32'h0F000000, 32'hFFFE0004};

    initial begin
        reset = 1'b1; flush = 1'b0; immediate = '0; mode = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        flush8 = 1'b0; immediate8 = '0; mode8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_ovalid", 64'(out_valid), 64'd0);
        check("rst_irdy", 64'(in_ready), 64'd1);
        check("rst_imm", 64'(output_imm), 64'd0);

        // Mode vectors, one cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(vec_imm[i], vec_mode[i]);
            step();
            in_valid = 1'b0;
            check("mode_lit", 64'(output_imm), 64'(vec_exp[i]));
            check("mode_model", ext_model(16, 32, 64'(vec_imm[i]), vec_mode[i]), 64'(vec_exp[i]));
            check("mode_valid", 64'(out_valid), 64'd1);
            step();
        end

        // Backpressure
        out_ready = 1'b0;
        drive(16'h0001, 2'b00); step();
        drive(16'h0002, 2'b00); step();
        check("bp_occ", 64'(occupancy), 64'd2);
        check("bp_irdy", 64'(in_ready), 64'd0);
        drive(16'h0003, 2'b00); step();
        in_valid = 1'b0;
        check("bp_hold_occ", 64'(occupancy), 64'd2);
        check("bp_hold_imm", 64'(output_imm), 64'h00000001);
        out_ready = 1'b1;
        step();
        check("bp_second", 64'(output_imm), 64'h00000002);
        step();
        check("bp_drained", 64'(out_valid), 64'd0);

        // Streaming
        for (int i = 0; i < 8; i++) begin
            drive(16'h0100 + 16'(i), 2'b00);
            step();
            check("stream_occ", 64'(occupancy), 64'd1);
            check("stream_imm", 64'(output_imm), 64'h100 + 64'(i));
        end
        in_valid = 1'b0;
        step();

        // Flush in TWO with a concurrent push
        out_ready = 1'b0;
        drive(16'h1111, 2'b00); step();
        drive(16'h2222, 2'b00); step();
        check("fl_pre_occ", 64'(occupancy), 64'd2);
        flush = 1'b1;
        drive(16'hDEAD, 2'b00);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_occ", 64'(occupancy), 64'd0);
        check("fl_ovalid", 64'(out_valid), 64'd0);
        check("fl_imm", 64'(output_imm), 64'd0);
        out_ready = 1'b1;
        step(); step();
        check("fl_never", 64'(out_valid), 64'd0);

        // Reset mid-operation with flush and push
        out_ready = 1'b0;
        drive(16'h3333, 2'b01); step();
        drive(16'h4444, 2'b01); step();
        check("rm_pre_occ", 64'(occupancy), 64'd2);
        reset = 1'b1; flush = 1'b1;
        drive(16'h5555, 2'b00);
        step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check("rm_occ", 64'(occupancy), 64'd0);
        check("rm_imm", 64'(output_imm), 64'd0);
        check("rm_irdy", 64'(in_ready), 64'd1);

        // Narrow parameterisation
        out_ready8 = 1'b1;
        immediate8 = 8'h80; mode8 = 2'b01; in_valid8 = 1'b1;
        step();
        check("p8_sext", 64'(output_imm8), 64'hFF80);
        mode8 = 2'b11;
        step();
        in_valid8 = 1'b0;
        check("p8_branch", 64'(output_imm8), 64'hFE00);
        check("p8_model", ext_model(8, 16, 64'h80, 2'b11), 64'hFE00);
        step();
        check("p8_drain", 64'(out_valid8), 64'd0);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
